column_carry_assembler: RTL and testbench

Consumer end of the sliced big-integer multiplier datapath. Column slices deliver one column sum per word position: a 79-bit middle part plus a 2-bit upper part. This block accepts those column sums in order, LSW first, and ripples the inter-column carries. It emits the final normalized product as a stream of WORD_W-bit words plus one closing carry word for the downstream reduction/readout logic.

---
 rtl/column_carry_assembler.sv | 125 ++++++++++++
 tb/tb_column_carry_assembler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_carry_assembler.sv
`default_nettype none
// ============================================================================
// Module   : column_carry_assembler
// Purpose  : Accepts column sums LSW first, ripples inter-column carries and
//            streams normalized product words followed by one carry word.
// Revision : 1.0 - initial release
// ============================================================================
module column_carry_assembler #(
    parameter int WORD_W   = 80,
    parameter int NUM_COLS = 39,
    parameter int CNT_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-2:0] col_mid,
    input  logic [1:0]        col_up,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NUM_COLS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_c;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_done;

    logic              w_free;
    logic              w_accept;
    logic [WORD_W+1:0] w_sum;

    // Output register can take a new word when empty or being drained now.
    assign w_free   = !r_out_valid || out_ready;
    assign in_ready = (r_state == S_RUN) && w_free;
    assign w_accept = in_valid && in_ready;
    // The carry never exceeds 2, so the sum fits in WORD_W+2 bits.
    assign w_sum    = {1'b0, col_up, col_mid} + {{WORD_W{1'b0}}, r_c};

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (en) w_next_state = S_RUN;
            S_RUN:   if (w_accept && (r_cnt == C_LAST_CNT)) w_next_state = S_FLUSH;
            S_FLUSH: if (w_free) w_next_state = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_c         <= 2'd0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_c   <= 2'd0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_out_data  <= w_sum[WORD_W-1:0];
                        r_c         <= w_sum[WORD_W+1:WORD_W];
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_cnt       <= r_cnt + CNT_W'(1);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (w_free) begin
                        r_out_data  <= {{(WORD_W-2){1'b0}}, r_c};
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_c         <= 2'd0;
                    end
                end
                S_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_column_carry_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_carry_assembler
// Purpose  : Directed scoreboard bench for column_carry_assembler (4 columns).
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_carry_assembler;

    localparam int WORD_W = 80;
    localparam int NC     = 4;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-2:0] col_mid;
    logic [1:0]        col_up;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    column_carry_assembler #(
        .WORD_W  (WORD_W),
        .NUM_COLS(NC),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .col_mid  (col_mid),
        .col_up   (col_up),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_words = 0;
    bit          exp_done_next = 1'b0;
    logic [1:0]  ups[NC];
    logic [78:0] mids[NC];

    // Output side: every handshaken word is popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_done_next) begin
            total++;
            assert (done === 1'b1) else begin
                bad++;
                $error("FAIL done_after_last got=%b exp=1", done);
            end
            exp_done_next = 1'b0;
        end
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_words++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_word got=%h exp=none", out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                assert (out_data === e.data && out_last === e.last) else begin
                    bad++;
                    $error("FAIL word got=%h/%b exp=%h/%b", out_data, out_last, e.data, e.last);
                end
                exp_done_next = e.last;
            end
        end
    end

    task automatic chk(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Golden result: the whole weighted sum as one wide integer, sliced into words.
    task automatic start_op();
        logic [WORD_W*(NC+1)-1:0] acc;
        logic [WORD_W*(NC+1)-1:0] term;
        exp_t e;
        acc = '0;
        for (int i = 0; i < NC; i++) begin
            term = {{(WORD_W*(NC+1)-81){1'b0}}, ups[i], mids[i]};
            acc  = acc + (term << (WORD_W * i));
        end
        for (int k = 0; k <= NC; k++) begin
            e.data = acc[WORD_W*k +: WORD_W];
            e.last = (k == NC);
            sb.push_back(e);
        end
        n_words = 0;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic send_col(input int idx, output int tries);
        bit acc;
        acc      = 1'b0;
        tries    = 0;
        col_up   = ups[idx];
        col_mid  = mids[idx];
        in_valid = 1'b1;
        while (!acc && tries < 100) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL accept_timeout got=0 exp=1 col=%0d", idx);
        end
    endtask

    task automatic finish_op(input string tag);
        bit   seen;
        logic pb;
        seen = 1'b0;
        pb   = busy;
        for (int k = 0; k < 60; k++) begin
            pb = busy;
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, WORD_W'(seen), WORD_W'(1));
        chk({tag, "_busy_before_done"}, WORD_W'(pb), WORD_W'(1));
        chk({tag, "_busy_with_done"}, WORD_W'(busy), WORD_W'(0));
        chk({tag, "_word_count"}, WORD_W'(n_words), WORD_W'(NC + 1));
        chk({tag, "_sb_empty"}, WORD_W'(sb.size()), WORD_W'(0));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, WORD_W'(done), WORD_W'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tries;
        int   dcount;
        exp_t head;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        col_up = '0; col_mid = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", WORD_W'(out_valid), WORD_W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_flags", WORD_W'({out_last, done, busy, in_ready}), WORD_W'(0));
        @(posedge clk); #1 rst = 1'b0;

        // All-zero columns at full throughput.
        for (int i = 0; i < NC; i++) begin ups[i] = 2'b00; mids[i] = '0; end
        start_op();
        chk("busy_after_en", WORD_W'(busy), WORD_W'(1));
        for (int i = 0; i < NC; i++) begin
            send_col(i, tries);
            chk("zero_first_try", WORD_W'(tries), WORD_W'(1));
        end
        finish_op("zero");

        // Maximum column value in col0 only.
        for (int i = 0; i < NC; i++) begin ups[i] = 2'b00; mids[i] = '0; end
        ups[0] = 2'b11; mids[0] = {79{1'b1}};
        start_op();
        for (int i = 0; i < NC; i++) send_col(i, tries);
        finish_op("max0");

        // Carry reaching 2.
        ups[1] = 2'b11; mids[1] = {79{1'b1}};
        start_op();
        for (int i = 0; i < NC; i++) send_col(i, tries);
        finish_op("ripple");

        // Backpressure after the first word.
        for (int i = 0; i < NC; i++) begin
            ups[i]  = 2'($urandom_range(0, 3));
            mids[i] = 79'({$urandom(), $urandom(), $urandom()});
        end
        out_ready = 1'b0;
        start_op();
        send_col(0, tries);
        head     = sb[0];
        col_up   = ups[1];
        col_mid  = mids[1];
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", WORD_W'(in_ready), WORD_W'(0));
            chk("bp_out_valid", WORD_W'(out_valid), WORD_W'(1));
            chk("bp_out_data", out_data, head.data);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_col(1, tries);
        chk("bp_resume_first_try", WORD_W'(tries), WORD_W'(1));
        send_col(2, tries);
        send_col(3, tries);
        finish_op("bp");

        // en pulse while busy must be ignored.
        for (int i = 0; i < NC; i++) begin
            ups[i]  = 2'($urandom_range(0, 3));
            mids[i] = 79'({$urandom(), $urandom(), $urandom()});
        end
        start_op();
        send_col(0, tries);
        send_col(1, tries);
        en = 1'b1;
        send_col(2, tries);
        en = 1'b0;
        send_col(3, tries);
        finish_op("en_busy");

        // Reset after two columns: result discarded, no done.
        start_op();
        send_col(0, tries);
        send_col(1, tries);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", WORD_W'(out_valid), WORD_W'(0));
        chk("mid_rst_busy", WORD_W'(busy), WORD_W'(0));
        chk("mid_rst_in_ready", WORD_W'(in_ready), WORD_W'(0));
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            if (done === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", WORD_W'(dcount), WORD_W'(0));
        @(posedge clk); #1;

        // Fresh run after reset starts from a clear carry.
        for (int i = 0; i < NC; i++) begin ups[i] = 2'b00; mids[i] = '0; end
        ups[0] = 2'b11; mids[0] = {79{1'b1}};
        ups[1] = 2'b11; mids[1] = {79{1'b1}};
        ups[3] = 2'b10; mids[3] = 79'd5;
        start_op();
        for (int i = 0; i < NC; i++) send_col(i, tries);
        finish_op("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
